// File: rtl/wb_commit_pkg.sv
// rtl/wb_commit_pkg.sv - shared encodings and constants for the write-back commit unit
package wb_commit_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam int          CAUSE_ECALL_M = 11;

   typedef enum logic [2:0] {
      RD_NONE  = 3'd0,
      RD_ALU   = 3'd1,
      RD_MEM   = 3'd2,
      RD_SNPC  = 3'd3,
      RD_CSRRW = 3'd4,
      RD_CSRRS = 3'd5,
      RD_CMP   = 3'd6
   } rdsrc_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMMIT,
      S_TRAP_CAUSE,
      S_REDIR
   } state_e;

   function automatic logic gpr_writes(input logic [2:0] src, input logic [4:0] rd);
      return (src >= 3'(RD_ALU)) && (src <= 3'(RD_CMP)) && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/wb_commit_if.sv
// rtl/wb_commit_if.sv - M->W stage valid/ready bus carrying one retiring instruction
interface wb_commit_if #(parameter int XLEN = 32);

   logic            s_valid;
   logic            s_ready;
   logic [XLEN-1:0] dnpcW;
   logic [XLEN-1:0] snpcW;
   logic [XLEN-1:0] pcW;
   logic [2:0]      rdregsrcW;
   logic [XLEN-1:0] mdataW;
   logic [XLEN-1:0] ALU_resultW;
   logic [XLEN-1:0] csrW;
   logic [XLEN-1:0] src2W;
   logic [11:0]     csraddrW;
   logic            cmp_resultW;
   logic            ecallW;
   logic [4:0]      rdW;

   modport master (
      output s_valid, dnpcW, snpcW, pcW, rdregsrcW, mdataW, ALU_resultW,
             csrW, src2W, csraddrW, cmp_resultW, ecallW, rdW,
      input  s_ready
   );

   modport slave (
      input  s_valid, dnpcW, snpcW, pcW, rdregsrcW, mdataW, ALU_resultW,
             csrW, src2W, csraddrW, cmp_resultW, ecallW, rdW,
      output s_ready
   );

endinterface

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - selects GPR and CSR write data from the retiring instruction fields
module wb_result_mux
   import wb_commit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      rdregsrc,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] mdata,
   input  logic [XLEN-1:0] snpc,
   input  logic [XLEN-1:0] csr,
   input  logic [XLEN-1:0] src2,
   input  logic            cmp_result,
   output logic [XLEN-1:0] gpr_wdata,
   output logic [XLEN-1:0] csr_wdata
);

   always_comb begin
      gpr_wdata = '0;
      case (rdregsrc)
         RD_ALU:   gpr_wdata = alu_result;
         RD_MEM:   gpr_wdata = mdata;
         RD_SNPC:  gpr_wdata = snpc;
         RD_CSRRW,
         RD_CSRRS: gpr_wdata = csr;
         RD_CMP:   gpr_wdata = {{(XLEN-1){1'b0}}, cmp_result};
         default:  gpr_wdata = '0;
      endcase
      // csrrw writes the operand, csrrs sets the operand bits in the old value
      csr_wdata = (rdregsrc == RD_CSRRS) ? (csr | src2) : src2;
   end

endmodule

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - write-back commit FSM: GPR/CSR writes, ecall trap, fetch redirect; WB_DIFFTEST_EN adds commit trace
module wb_commit
   import wb_commit_pkg::*;
#(
   parameter int          XLEN        = XLEN_DEF,
   parameter logic [11:0] MEPC_ADDR   = ADDR_MEPC,
   parameter logic [11:0] MCAUSE_ADDR = ADDR_MCAUSE,
   parameter int          ECALL_CAUSE = CAUSE_ECALL_M
) (
   input  logic            clk,
   input  logic            rst,
   wb_commit_if.slave      w,
   input  logic [XLEN-1:0] mtvec,
   output logic            gpr_wen,
   output logic [4:0]      gpr_waddr,
   output logic [XLEN-1:0] gpr_wdata,
   output logic            csr_wen,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            npc_valid,
   input  logic            npc_ready,
   output logic [XLEN-1:0] npc
`ifdef WB_DIFFTEST_EN
   ,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [63:0]     commit_cnt
`endif
);

   state_e          state;
   logic            ecall_q;
   logic [XLEN-1:0] dnpc_q;
   logic [XLEN-1:0] mux_gpr_wdata;
   logic [XLEN-1:0] mux_csr_wdata;
   logic            gpr_wr_d;
   logic            csr_wr_d;

   // Write pulses are registered at the handshake edge so they appear in COMMIT
   wb_result_mux #(.XLEN(XLEN)) u_mux (
      .rdregsrc   (w.rdregsrcW),
      .alu_result (w.ALU_resultW),
      .mdata      (w.mdataW),
      .snpc       (w.snpcW),
      .csr        (w.csrW),
      .src2       (w.src2W),
      .cmp_result (w.cmp_resultW),
      .gpr_wdata  (mux_gpr_wdata),
      .csr_wdata  (mux_csr_wdata)
   );

   assign gpr_wr_d = gpr_writes(w.rdregsrcW, w.rdW);
   assign csr_wr_d = (w.rdregsrcW == RD_CSRRW) ||
                     ((w.rdregsrcW == RD_CSRRS) && (w.src2W != '0));

`ifdef WB_DIFFTEST_EN
   logic [XLEN-1:0] pc_q;
   assign commit_pc = pc_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         ecall_q   <= 1'b0;
         dnpc_q    <= '0;
         w.s_ready <= 1'b1;
         gpr_wen   <= 1'b0;
         gpr_waddr <= '0;
         gpr_wdata <= '0;
         csr_wen   <= 1'b0;
         csr_waddr <= '0;
         csr_wdata <= '0;
         npc_valid <= 1'b0;
         npc       <= '0;
`ifdef WB_DIFFTEST_EN
         pc_q         <= '0;
         commit_valid <= 1'b0;
         commit_cnt   <= '0;
`endif
      end else begin
         gpr_wen   <= 1'b0;
         gpr_waddr <= '0;
         gpr_wdata <= '0;
         csr_wen   <= 1'b0;
         csr_waddr <= '0;
         csr_wdata <= '0;
`ifdef WB_DIFFTEST_EN
         commit_valid <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (w.s_valid) begin
                  ecall_q   <= w.ecallW;
                  dnpc_q    <= w.dnpcW;
                  w.s_ready <= 1'b0;
                  state     <= S_COMMIT;
`ifdef WB_DIFFTEST_EN
                  pc_q      <= w.pcW;
`endif
                  if (w.ecallW) begin
                     csr_wen   <= 1'b1;
                     csr_waddr <= MEPC_ADDR;
                     csr_wdata <= w.pcW;
                  end else begin
                     if (gpr_wr_d) begin
                        gpr_wen   <= 1'b1;
                        gpr_waddr <= w.rdW;
                        gpr_wdata <= mux_gpr_wdata;
                     end
                     if (csr_wr_d) begin
                        csr_wen   <= 1'b1;
                        csr_waddr <= w.csraddrW;
                        csr_wdata <= mux_csr_wdata;
                     end
                  end
               end
            end
            S_COMMIT: begin
               if (ecall_q) begin
                  csr_wen   <= 1'b1;
                  csr_waddr <= MCAUSE_ADDR;
                  csr_wdata <= XLEN'(ECALL_CAUSE);
                  state     <= S_TRAP_CAUSE;
               end else begin
                  npc_valid <= 1'b1;
                  npc       <= dnpc_q;
                  state     <= S_REDIR;
               end
            end
            S_TRAP_CAUSE: begin
               npc_valid <= 1'b1;
               npc       <= mtvec;
               state     <= S_REDIR;
            end
            S_REDIR: begin
               if (npc_ready) begin
                  npc_valid <= 1'b0;
                  w.s_ready <= 1'b1;
                  state     <= S_IDLE;
`ifdef WB_DIFFTEST_EN
                  commit_valid <= 1'b1;
                  commit_cnt   <= commit_cnt + 64'd1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Write-back commit unit; sink end of the M→W stage valid/ready bus.
- Accepts one retiring instruction per handshake and writes the GPR file and CSR file.
- Sequences ecall traps: writes mepc, then mcause, over a single CSR write port.
- Hands the committed next PC back to the fetch stage over its own valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- MEPC_ADDR, 12'h341, CSR address of mepc.
- MCAUSE_ADDR, 12'h342, CSR address of mcause.
- ECALL_CAUSE, 11, mcause value written on ecall (M-mode).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  W-bus instruction valid
- s_ready  out  1  unit ready to accept
- dnpcW, snpcW, pcW  in  32 each  dynamic next PC, static next PC, PC
- rdregsrcW  in  3  rd source: 0 none, 1 ALU, 2 mem, 3 snpc, 4 csrrw, 5 csrrs, 6 cmp
- mdataW, ALU_resultW, csrW, src2W  in  32 each  load data, ALU result, old CSR value, rs1/rs2 operand
- csraddrW  in  12  CSR address
- cmp_resultW, ecallW  in  1 each  compare result, ecall flag
- rdW  in  5  destination register
- mtvec  in  32  trap vector from the CSR file
- gpr_wen  out  1,  gpr_waddr  out  5,  gpr_wdata  out  32  GPR write port
- csr_wen  out  1,  csr_waddr  out  12,  csr_wdata  out  32  CSR write port
- npc_valid  out  1,  npc_ready  in  1,  npc  out  32  redirect to the fetch stage

Behaviour:
- Reset (async, rst=0): state=IDLE; all internal capture registers 0; every output 0 except s_ready=1.
- States and transitions:
  - IDLE: s_ready=1. On s_valid, capture all W inputs → COMMIT.
  - COMMIT: one cycle. ecallW → TRAP_CAUSE, else → REDIR.
  - TRAP_CAUSE: one cycle → REDIR.
  - REDIR: npc_valid=1; hold npc stable until npc_ready. npc_ready → IDLE.
- GPR write (COMMIT only): gpr_wen=1 iff rdregsrc∈{1..6} and rd≠0. gpr_wdata by source:
  - 1 → ALU_result; 2 → mdata; 3 → snpc
  - 4, 5 → csr (old CSR value)
  - 6 → {31'b0, cmp_result}
  - rd==0 → gpr_wen=0, no write.
- CSR write (COMMIT only, when not ecall):
  - rdregsrc=4 → csr_wen=1, addr=csraddr, data=src2.
  - rdregsrc=5 → csr_wen=1, data=csr|src2; no write when src2==0.
- ecall: GPR write suppressed.
  - COMMIT: csr_wen=1, addr=MEPC_ADDR, data=pc.
  - TRAP_CAUSE: csr_wen=1, addr=MCAUSE_ADDR, data=ECALL_CAUSE.
- npc value: mtvec (sampled in TRAP_CAUSE) if ecall, else dnpc.
- Write-port pulses: gpr_wen and csr_wen are single-cycle, registered from state, never asserted in IDLE or REDIR.
- Throughput and latency:
  - Non-ecall: handshake → gpr write next cycle → npc_valid the cycle after.
  - Ecall: one extra cycle.
  - Minimum 3 cycles per instruction; s_ready is low outside IDLE.
- npc_ready held high: REDIR lasts exactly one cycle.
- npc_ready held low: unit stalls in REDIR indefinitely with outputs stable; s_ready stays 0.
- s_valid while busy: ignored; upstream must hold its data.
- Reset mid-operation: immediate return to IDLE; pending commit discarded; no write pulse emitted.

Optional Feature:
- Macro WB_DIFFTEST_EN. When defined, adds three outputs:
  - commit_valid: 1-cycle pulse on the REDIR→IDLE transition.
  - commit_pc (32): captured pc.
  - commit_cnt (64): retired-instruction counter; increments on commit_valid, reset 0, wraps at 2^64.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package: rdregsrc encodings (RD_NONE..RD_CMP), CSR address constants, ECALL_CAUSE, state encoding.
- One sub-module, wb_result_mux: combinational gpr_wdata/csr_wdata selection from captured fields.

Test Plan:
- ALU result: rdregsrc=1, rd=5, ALU_result=32'h1234 → gpr_wen pulse 1 cycle after handshake (x5←0x1234); npc_valid next cycle with npc=dnpc.
- rd=0 with rdregsrc=2 → gpr_wen never asserted; npc handshake still completes.
- ecall: pc=0x80000010, mtvec=0x80000100 → mepc←0x80000010, then mcause←11, then npc=0x80000100; no GPR write.
- csrrs: csr=0x8, src2=0x3, rd=2 → x2←0x8 and CSR←0xB in the same cycle. Repeat with src2=0 → csr_wen=0.
- npc_ready held low 5 cycles → npc_valid and npc stable; s_ready=0; second s_valid is not accepted until the redirect completes.
- Reset asserted during TRAP_CAUSE → outputs 0, s_ready=1 immediately; no mcause write. With WB_DIFFTEST_EN: commit_cnt=0 after reset and 3 after three commits.
